// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES scheduler types, widths and round-count helper
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int nr(input int size);
        return size / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_cipher_sched_rr_arbiter.sv
// rtl/aes_cipher_sched_rr_arbiter.sv - combinational round-robin arbiter, search upward from ptr with wrap
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/aes_cipher_sched.sv
// rtl/aes_cipher_sched.sv - shares one iterative Cipher core between NREQ requesters
module aes_cipher_sched
    import aes_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SIZE     = 128,
    parameter int CORE_LAT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*BLOCK_W-1:0]   req_plaintext,
    input  logic [NREQ*SIZE-1:0]      req_key,
    output logic                      core_reset,
    output logic                      core_enable,
    output logic [BLOCK_W-1:0]        core_plaintext,
    output logic [SIZE-1:0]           core_key,
    input  logic [BLOCK_W-1:0]        core_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BLOCK_W-1:0]        rsp_data,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(CORE_LAT + 1);

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Handshake outputs are masked during reset so nothing is offered or accepted on that edge.
    assign req_ready   = (state == IDLE && !reset) ? gnt : '0;
    assign core_reset  = reset | (state == CLR);
    assign core_enable = (state == RUN) & ~reset;
    assign rsp_valid   = (state == HOLD) & ~reset;
    assign busy        = (state != IDLE) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            cnt            <= '0;
            rsp_data       <= '0;
            rsp_id         <= '0;
            core_plaintext <= '0;
            core_key       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        core_plaintext <= req_plaintext[BLOCK_W*gnt_idx +: BLOCK_W];
                        core_key       <= req_key[SIZE*gnt_idx +: SIZE];
                        rsp_id         <= gnt_idx;
                        rr_ptr         <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state          <= CLR;
                    end
                end
                CLR: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // Final enable cycle: the core output is settled, take it now.
                    if (cnt == CW'(CORE_LAT - 1)) begin
                        rsp_data <= core_out;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
